// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared decode types for the instruction front end.
//   instr_class_e   : 3-bit instruction class
//   OP_*            : opcode constants recognised by the decoder
//   decoded_entry_t : one assembled/decoded instruction as held in the issue buffer
//   classify()      : opcode -> class mapping (anything unlisted is ILLEGAL)
package cpu_pkg;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_REG     = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_PROC    = 3'd4,
    CLS_INT     = 3'd5,
    CLS_IO      = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_e;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_REG   = 8'h12;
  localparam logic [7:0] OP_LOAD  = 8'h09;
  localparam logic [7:0] OP_STORE = 8'h0E;
  localparam logic [7:0] OP_PROC0 = 8'h18;
  localparam logic [7:0] OP_PROC1 = 8'h19;
  localparam logic [7:0] OP_INT0  = 8'h1A;
  localparam logic [7:0] OP_INT1  = 8'h1B;
  localparam logic [7:0] OP_INT2  = 8'h1C;
  localparam logic [7:0] OP_IO0   = 8'h1D;
  localparam logic [7:0] OP_IO1   = 8'h1E;
  localparam logic [7:0] OP_IO2   = 8'h1F;

  typedef struct packed {
    logic [7:0]   opcode;
    logic [7:0]   arg;
    logic [15:0]  operand;
    logic [15:0]  pc;
    instr_class_e cls;
  } decoded_entry_t;

  function automatic instr_class_e classify(input logic [7:0] op);
    instr_class_e c;
    case (op)
      OP_NOP:                    c = CLS_NOP;
      OP_REG:                    c = CLS_REG;
      OP_LOAD:                   c = CLS_LOAD;
      OP_STORE:                  c = CLS_STORE;
      OP_PROC0, OP_PROC1:        c = CLS_PROC;
      OP_INT0, OP_INT1, OP_INT2: c = CLS_INT;
      OP_IO0, OP_IO1, OP_IO2:    c = CLS_IO;
      default:                   c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo -- circular buffer of decoded instructions.
//   clk, rst_n     : clock, synchronous active-low reset
//   flush          : empties the buffer and rewinds both pointers
//   push/push_data : write one entry (caller guarantees not full)
//   pop            : retire the head entry (caller guarantees not empty)
//   head           : entry at the read pointer
//   count          : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  decoded_entry_t           push_data,
  input  logic                     pop,
  output decoded_entry_t           head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  decoded_entry_t mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_decode_issue.sv
// instr_decode_issue -- pairs fetched RAM words into instructions, decodes
// them and queues them for issue.
//   clk, rst_n            : clock, synchronous active-low reset
//   flush                 : drop buffered entries and any held word0
//   in_valid/in_ready     : fetch handshake; in_word at in_addr
//   out_valid/out_ready   : issue handshake for the buffer head
//   out_opcode/out_arg    : word0[15:8] / word0[7:0] of the head entry
//   out_operand/out_pc    : word1 / address of word0 of the head entry
//   out_class             : instr_class_e of the head entry
//   illegal               : high in the cycle an ILLEGAL entry is pushed
// Optional build macro DECODE_STATS_EN adds saturating 16-bit counters:
//   issued_cnt (pops) and illegal_cnt (ILLEGAL pushes); reset clears them,
//   flush does not.
module instr_decode_issue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_word,
  input  logic [15:0] in_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_opcode,
  output logic [7:0]  out_arg,
  output logic [15:0] out_operand,
  output logic [15:0] out_pc,
  output logic [2:0]  out_class,
  output logic        illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [15:0] issued_cnt,
  output logic [15:0] illegal_cnt
`endif
);

  localparam int unsigned    CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  typedef enum logic {W0, W1} asm_state_e;

  asm_state_e     state;
  asm_state_e     state_next;
  logic [15:0]    w0_word;
  logic [15:0]    w0_addr;
  logic           accept;
  logic           pair_ok;
  logic           push;
  logic           capture_w0;
  logic           pop;
  logic [CW-1:0]  count;
  decoded_entry_t entry;
  decoded_entry_t head;

  assign in_ready  = rst_n && !flush && (count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign pair_ok   = (in_addr == w0_addr + 16'd1);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n || flush) state <= W0;
    else                 state <= state_next;
  end

  // Next state: a non-adjacent word in W1 restarts assembly but stays in W1
  always_comb begin
    state_next = state;
    case (state)
      W0:      if (accept)            state_next = W1;
      W1:      if (accept && pair_ok) state_next = W0;
      default:                        state_next = W0;
    endcase
  end

  // Outputs of the assembler: push on a matching word1, else latch a new word0
  always_comb begin
    push       = 1'b0;
    capture_w0 = 1'b0;
    if (accept) begin
      if (state == W1 && pair_ok) push       = 1'b1;
      else                        capture_w0 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w0_word <= '0;
      w0_addr <= '0;
    end else if (capture_w0) begin
      w0_word <= in_word;
      w0_addr <= in_addr;
    end
  end

  always_comb begin
    entry.opcode  = w0_word[15:8];
    entry.arg     = w0_word[7:0];
    entry.operand = in_word;
    entry.pc      = w0_addr;
    entry.cls     = classify(w0_word[15:8]);
  end

  assign illegal = push && (entry.cls == CLS_ILLEGAL);

  instr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .push_data(entry),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // Storage is not cleared on reset, so the head is masked while empty
  always_comb begin
    out_opcode  = '0;
    out_arg     = '0;
    out_operand = '0;
    out_pc      = '0;
    out_class   = '0;
    if (out_valid) begin
      out_opcode  = head.opcode;
      out_arg     = head.arg;
      out_operand = head.operand;
      out_pc      = head.pc;
      out_class   = head.cls;
    end
  end

`ifdef DECODE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      if (pop && issued_cnt != '1)      issued_cnt  <= issued_cnt + 16'd1;
      if (illegal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_issue.sv
// tb_instr_decode_issue -- self-checking bench for instr_decode_issue.
// A queue-based reference model tracks the expected buffer contents and the
// held word0; every cycle all outputs are compared against it, alongside a
// classification table and hand-written corner-case sequences.
module tb_instr_decode_issue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int NV    = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_word = '0;
  logic [15:0] in_addr = '0;
  logic        in_ready;
  logic        out_valid;
  logic        illegal;
  logic [7:0]  out_opcode;
  logic [7:0]  out_arg;
  logic [15:0] out_operand;
  logic [15:0] out_pc;
  logic [2:0]  out_class;
`ifdef DECODE_STATS_EN
  logic [15:0] issued_cnt;
  logic [15:0] illegal_cnt;
`endif

  always #5 clk = ~clk;

  instr_decode_issue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .in_addr    (in_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_arg    (out_arg),
    .out_operand(out_operand),
    .out_pc     (out_pc),
    .out_class  (out_class),
    .illegal    (illegal)
`ifdef DECODE_STATS_EN
    ,
    .issued_cnt (issued_cnt),
    .illegal_cnt(illegal_cnt)
`endif
  );

  typedef struct {
    logic [7:0]   op;
    logic [7:0]   arg;
    logic [15:0]  opd;
    logic [15:0]  pc;
    instr_class_e cls;
  } ent_t;

  typedef struct {
    logic [15:0]  w0;
    logic [15:0]  w1;
    instr_class_e cls;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        mq[$];
  bit          m_have = 1'b0;
  logic [15:0] m_w0 = '0;
  logic [15:0] m_a0 = '0;
  int          m_issued = 0;
  int          m_illegal = 0;
  logic [7:0]  popped[$];
  logic        last_in_ready = 1'b0;
  int          illegal_seen = 0;
  vec_t        tbl[NV];

  function automatic instr_class_e ref_class(input logic [7:0] op);
    if (op == 8'h00) return CLS_NOP;
    if (op == 8'h12) return CLS_REG;
    if (op == 8'h09) return CLS_LOAD;
    if (op == 8'h0E) return CLS_STORE;
    if (op >= 8'h18 && op <= 8'h19) return CLS_PROC;
    if (op >= 8'h1A && op <= 8'h1C) return CLS_INT;
    if (op >= 8'h1D && op <= 8'h1F) return CLS_IO;
    return CLS_ILLEGAL;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, compare at negedge against the model, advance the model
  task automatic cycle(input bit r, input bit f, input bit iv, input logic [15:0] w,
                       input logic [15:0] a, input bit ordy);
    bit          exp_ir;
    bit          exp_push;
    logic [15:0] nxt;
    ent_t        ne;
    logic [7:0]  e_op;
    logic [7:0]  e_arg;
    logic [15:0] e_opd;
    logic [15:0] e_pc;
    logic [2:0]  e_cls;
    rst_n = r; flush = f; in_valid = iv; in_word = w; in_addr = a; out_ready = ordy;
    @(negedge clk);
    nxt      = m_a0 + 16'd1;
    exp_ir   = r && !f && (mq.size() < DEPTH);
    exp_push = iv && exp_ir && m_have && (a == nxt);
    ne.op  = m_w0[15:8];
    ne.arg = m_w0[7:0];
    ne.opd = w;
    ne.pc  = m_a0;
    ne.cls = ref_class(m_w0[15:8]);
    if (mq.size() != 0) begin
      e_op = mq[0].op; e_arg = mq[0].arg; e_opd = mq[0].opd; e_pc = mq[0].pc;
      e_cls = 3'(mq[0].cls);
    end else begin
      e_op = '0; e_arg = '0; e_opd = '0; e_pc = '0; e_cls = '0;
    end
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_opcode", out_opcode, e_op);
    chk("out_arg", out_arg, e_arg);
    chk("out_operand", out_operand, e_opd);
    chk("out_pc", out_pc, e_pc);
    chk("out_class", out_class, e_cls);
    chk("illegal", illegal, exp_push && (ne.cls == CLS_ILLEGAL));
`ifdef DECODE_STATS_EN
    chk("issued_cnt", issued_cnt, m_issued);
    chk("illegal_cnt", illegal_cnt, m_illegal);
`endif
    last_in_ready = in_ready;
    if (illegal) illegal_seen++;
    if (out_valid && ordy && r && !f) popped.push_back(out_opcode);
    if (!r) begin
      mq.delete(); m_have = 1'b0; m_issued = 0; m_illegal = 0;
    end else if (f) begin
      mq.delete(); m_have = 1'b0;
    end else begin
      if (mq.size() != 0 && ordy) begin
        void'(mq.pop_front());
        if (m_issued < 65535) m_issued++;
      end
      if (iv && exp_ir) begin
        if (exp_push) begin
          mq.push_back(ne);
          if (ne.cls == CLS_ILLEGAL && m_illegal < 65535) m_illegal++;
          m_have = 1'b0;
        end else begin
          m_have = 1'b1; m_w0 = w; m_a0 = a;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic [15:0] a, input bit ordy);
    int n = 0;
    do begin
      cycle(1'b1, 1'b0, 1'b1, w, a, ordy);
      n++;
    end while (!last_in_ready && n < 40);
    if (!last_in_ready) begin
      checks++; errors++;
      $display("FAIL send_word_timeout: got in_ready 0 expected 1 for word 0x%0h", w);
    end
  endtask

  task automatic idle(input bit ordy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, ordy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ta;
    logic [15:0] ra;
    logic [15:0] rw;
    logic [15:0] rad;
    bit          rr, rf, riv, ro;
    logic [7:0]  exp_ops[5];

    tbl[0]  = '{16'h0011, 16'h1111, CLS_NOP};
    tbl[1]  = '{16'h1222, 16'h2222, CLS_REG};
    tbl[2]  = '{16'h0933, 16'h3333, CLS_LOAD};
    tbl[3]  = '{16'h0E44, 16'h4444, CLS_STORE};
    tbl[4]  = '{16'h1855, 16'h5555, CLS_PROC};
    tbl[5]  = '{16'h1966, 16'h6666, CLS_PROC};
    tbl[6]  = '{16'h1A77, 16'h7777, CLS_INT};
    tbl[7]  = '{16'h1B88, 16'h8888, CLS_INT};
    tbl[8]  = '{16'h1C99, 16'h9999, CLS_INT};
    tbl[9]  = '{16'h1DAA, 16'hAAAA, CLS_IO};
    tbl[10] = '{16'h1EBB, 16'hBBBB, CLS_IO};
    tbl[11] = '{16'h1FCC, 16'hCCCC, CLS_IO};
    tbl[12] = '{16'hFBDD, 16'hDDDD, CLS_ILLEGAL};
    tbl[13] = '{16'hFEEE, 16'hEEEE, CLS_ILLEGAL};
    tbl[14] = '{16'hFFFF, 16'hFFFF, CLS_ILLEGAL};
    tbl[15] = '{16'h0101, 16'h0101, CLS_ILLEGAL};
    tbl[16] = '{16'h1302, 16'h0202, CLS_ILLEGAL};
    tbl[17] = '{16'h2003, 16'h0303, CLS_ILLEGAL};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_opcode", out_opcode, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_illegal", illegal, 0);

    // Classification table
    for (int i = 0; i < NV; i++) begin
      ta = 16'h0300 + 16'(2 * i);
      illegal_seen = 0;
      send_word(tbl[i].w0, ta, 1'b1);
      send_word(tbl[i].w1, ta + 16'd1, 1'b1);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_class", out_class, tbl[i].cls);
      chk("tbl_opcode", out_opcode, tbl[i].w0[15:8]);
      chk("tbl_operand", out_operand, tbl[i].w1);
      chk("tbl_illegal_pulse", illegal_seen, tbl[i].cls == CLS_ILLEGAL);
    end
    idle(1'b1, 2);

    // Basic pair, latency 1
    send_word(16'h1210, 16'd50, 1'b1);
    chk("basic_not_yet_valid", out_valid, 0);
    send_word(16'h0A34, 16'd51, 1'b1);
    chk("basic_valid", out_valid, 1);
    chk("basic_opcode", out_opcode, 8'h12);
    chk("basic_arg", out_arg, 8'h10);
    chk("basic_operand", out_operand, 16'h0A34);
    chk("basic_pc", out_pc, 16'd50);
    chk("basic_class", out_class, CLS_REG);
    idle(1'b1, 2);

    // Non-adjacent word drops held word0
    send_word(16'h0911, 16'd52, 1'b1);
    send_word(16'h1800, 16'd60, 1'b1);
    chk("drop_no_entry", out_valid, 0);
    send_word(16'h0007, 16'd61, 1'b1);
    chk("drop_valid", out_valid, 1);
    chk("drop_opcode", out_opcode, 8'h18);
    chk("drop_pc", out_pc, 16'd60);
    chk("drop_class", out_class, CLS_PROC);
    idle(1'b1, 1);
    chk("drop_single_entry", out_valid, 0);

    // Address wrap between word0 and word1
    send_word(16'h0901, 16'hFFFF, 1'b1);
    send_word(16'h4444, 16'h0000, 1'b1);
    chk("wrap_opcode", out_opcode, 8'h09);
    chk("wrap_pc", out_pc, 16'hFFFF);
    idle(1'b1, 2);

    // Fill to DEPTH with out_ready low, then release
    exp_ops = '{8'h00, 8'h12, 8'h09, 8'h0E, 8'h19};
    popped.delete();
    for (int k = 0; k < 4; k++) begin
      send_word({exp_ops[k], 8'(k)}, 16'h0400 + 16'(2 * k), 1'b0);
      send_word(16'hA000 + 16'(k), 16'h0401 + 16'(2 * k), 1'b0);
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_opcode, 8'h00);
    send_word({exp_ops[4], 8'h04}, 16'h0408, 1'b1);
    send_word(16'hA004, 16'h0409, 1'b1);
    idle(1'b1, 8);
    chk("full_pop_count", popped.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < popped.size()) chk("full_order", popped[k], exp_ops[k]);

    // Illegal pulse of exactly one cycle
    illegal_seen = 0;
    send_word(16'hFB00, 16'd66, 1'b1);
    send_word(16'h0000, 16'd67, 1'b1);
    chk("ill_pulse", illegal_seen, 1);
    chk("ill_class", out_class, CLS_ILLEGAL);
    idle(1'b1, 3);
    chk("ill_pulse_once", illegal_seen, 1);
    chk("ill_issued", out_valid, 0);

    // Flush with 3 entries buffered and a word0 held at 199
    for (int k = 0; k < 3; k++) begin
      send_word(16'h1200 + 16'(k), 16'h0500 + 16'(2 * k), 1'b0);
      send_word(16'hB000, 16'h0501 + 16'(2 * k), 1'b0);
    end
    send_word(16'h0E77, 16'd199, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 16'h1234, 16'd200, 1'b1);
    chk("flush_out_valid", out_valid, 0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("flush_in_ready", in_ready, 1);
    send_word(16'h1D05, 16'd200, 1'b1);
    chk("flush_w0_cleared", out_valid, 0);
    send_word(16'h1234, 16'd201, 1'b1);
    chk("flush_opcode", out_opcode, 8'h1D);
    chk("flush_pc", out_pc, 16'd200);
    chk("flush_class", out_class, CLS_IO);
    idle(1'b1, 2);

    // Reset mid-stream
    send_word(16'h1A10, 16'h00F0, 1'b0);
    send_word(16'h2222, 16'h00F1, 1'b0);
    send_word(16'h1A00, 16'h0100, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h1111, 16'h0101, 1'b1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_opcode", out_opcode, 0);
    chk("mrst_arg", out_arg, 0);
    chk("mrst_operand", out_operand, 0);
    chk("mrst_pc", out_pc, 0);
    chk("mrst_class", out_class, 0);
    chk("mrst_illegal", illegal, 0);
`ifdef DECODE_STATS_EN
    chk("mrst_issued_cnt", issued_cnt, 0);
    chk("mrst_illegal_cnt", illegal_cnt, 0);
`endif
    send_word(16'h1C01, 16'h0101, 1'b1);
    chk("mrst_w0_dropped", out_valid, 0);
    send_word(16'h5555, 16'h0102, 1'b1);
    chk("mrst_opcode_after", out_opcode, 8'h1C);
    chk("mrst_pc_after", out_pc, 16'h0101);
    idle(1'b1, 2);

    // Randomized traffic against the model
    ra = 16'h1000;
    for (int n = 0; n < 600; n++) begin
      rr  = ($urandom_range(0, 199) != 0);
      rf  = ($urandom_range(0, 39) == 0);
      riv = ($urandom_range(0, 3) != 0);
      ro  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) rw = 16'($urandom);
      else rw = {tbl[$urandom_range(0, NV - 1)].w0[15:8], 8'($urandom)};
      rad = ($urandom_range(0, 9) == 0) ? 16'($urandom) : ra;
      cycle(rr, rf, riv, rw, rad, ro);
      if (riv && last_in_ready) ra = rad + 16'd1;
    end
    idle(1'b1, 6);
    chk("final_drained", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_issue.md
INSTR_DECODE_ISSUE -- requirements
Module: instr_decode_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of decoded-instruction buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port flush  input  1  discard all buffered and partial instructions.
REQ-005 SHALL have ports in_valid / in_ready / in_word / in_addr  in/out/in/in  1/1/16/16  fetched RAM word and its address, handshake on in_valid&&in_ready.
REQ-006 SHALL have ports out_valid / out_ready  out/in  1/1  issue handshake, transfer on out_valid&&out_ready.
REQ-007 SHALL have ports out_opcode 8, out_arg 8, out_operand 16, out_pc 16, out_class 3  all outputs  decoded head entry: word0[15:8], word0[7:0], word1, word0 address, instruction class.
REQ-008 SHALL have port illegal  output  1  one-cycle pulse when an ILLEGAL-class entry is pushed.

Function
REQ-009 SHALL assemble instructions from two consecutive words: word0 (opcode/arg) then word1 (operand), using assembler states W0 and W1.
REQ-010 SHALL, in W1, accept a word only if in_addr == word0 address + 1 (16-bit wrap); otherwise drop the held word0, treat the new word as word0, and stay in W1.
REQ-011 SHALL push the assembled entry into the buffer on the same edge that word1 is accepted; out_valid rises one cycle later (latency 1).
REQ-012 SHALL classify by opcode: 0x00 NOP; 0x12 REG; 0x09 LOAD; 0x0E STORE; 0x18,0x19 PROC; 0x1A,0x1B,0x1C INT; 0x1D,0x1E,0x1F IO; any other value ILLEGAL (including 0xFB/0xFE/0xFF).
REQ-013 SHALL drive in_ready = rst_n && !flush && (count < DEPTH), combinationally from the registered count.
REQ-014 SHALL drive out_valid = (count != 0); out_* fields SHALL be held stable while out_valid && !out_ready.
REQ-015 SHALL, on simultaneous push and pop, leave count unchanged and preserve order; push when full is impossible by REQ-013.
REQ-016 SHALL keep read/write pointers modulo DEPTH, wrapping without loss.
REQ-017 SHALL, on flush, clear count, reset both pointers, return assembler to W0, and ignore in_valid and out_ready that cycle; flush has priority over push/pop.
REQ-018 SHALL enqueue ILLEGAL entries like any other class and pulse illegal in the push cycle.

Reset
REQ-019 SHALL, while rst_n == 0 at posedge, set count=0, pointers=0, assembler=W0, illegal=0, out_valid=0, out_* fields=0, in_ready=0.
REQ-020 SHALL discard any partial word0 and buffered entries on reset mid-operation; the first edge with rst_n=1 accepts input normally.

Configuration
REQ-021 SHALL, with DECODE_STATS_EN defined, provide outputs issued_cnt 16 and illegal_cnt 16, counting pops and ILLEGAL pushes, saturating at 0xFFFF and cleared by reset, not by flush.
REQ-022 SHALL, without DECODE_STATS_EN, omit both counters and ports; all other behaviour is identical.

Structure
REQ-023 SHALL take the instr_class_e enum (3 bits), the opcode constants and the decoded-entry struct from the shared package cpu_pkg.
REQ-024 SHALL implement the buffer as sub-module instr_fifo (parameter DEPTH, push/pop/flush, count); decode and assembly stay in the top module.

Verification
REQ-025 SHALL cover: words 0x1210@50, 0x0A34@51 with out_ready=1 -> one cycle later out_valid=1, opcode 0x12, arg 0x10, operand 0x0A34, pc 50, class REG.
REQ-026 SHALL cover: 0x0911@52, 0x1800@60, 0x0007@61 -> 0x0911 dropped; single entry opcode 0x18, pc 60, class PROC.
REQ-027 SHALL cover: out_ready=0, 5 back-to-back instructions with DEPTH=4 -> in_ready=0 after the 4th push; release -> all 5 issued in order with no loss.
REQ-028 SHALL cover: word pair 0xFB00@66, 0x0000@67 -> illegal pulse of exactly 1 cycle; entry class ILLEGAL, issued normally.
REQ-029 SHALL cover: flush with 3 entries buffered and word0 held -> next cycle out_valid=0 and count=0; a following pair issues correctly.
REQ-030 SHALL cover: rst_n=0 for 1 cycle mid-stream -> all outputs zero; with DECODE_STATS_EN, issued_cnt=0 after reset.
